// File: rtl/mixed_reduce_gate.sv
// Multi-cycle reduction gate: folds CHUNK bits of the latched operand per clock
// for AND/OR/XOR/NAND, exiting early once the result can no longer change.
module mixed_reduce_gate #(
  parameter  int WIDTH = 16,
  parameter  int CHUNK = 4,
  localparam int N     = WIDTH / CHUNK,
  localparam int CW    = $clog2(N + 1),
  localparam int KW    = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             f,
  output logic [CW-1:0]    cnt
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  typedef enum logic [1:0] {OP_AND = 2'b00, OP_OR = 2'b01, OP_XOR = 2'b10, OP_NAND = 2'b11} op_t;

  state_t           state, state_d;
  op_t              op_q;
  logic [WIDTH-1:0] a_q;
  logic [KW-1:0]    k;
  logic [CW-1:0]    cnt_q;
  logic             acc;
  logic [CHUNK-1:0] chunk;
  logic             acc_fold;
  logic             exit_now;
  logic             and_like;

  always_comb begin
    chunk    = a_q[int'(k)*CHUNK +: CHUNK];
    and_like = (op_q == OP_AND) || (op_q == OP_NAND);
    case (op_q)
      OP_AND, OP_NAND: acc_fold = acc & (&chunk);
      OP_OR:           acc_fold = acc | (|chunk);
      default:         acc_fold = acc ^ (^chunk);
    endcase
    // The result is decided once the accumulator hits the op's dominant value.
    exit_now = (k == KW'(N - 1))
            || (and_like && !acc_fold)
            || ((op_q == OP_OR) && acc_fold);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d   = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    f         = 1'b0;
    cnt       = '0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = RUN;
      end
      RUN: begin
        if (exit_now) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        f         = acc ^ (op_q == OP_NAND);
        cnt       = cnt_q;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q   <= '0;
      op_q  <= OP_AND;
      k     <= '0;
      cnt_q <= '0;
      acc   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q   <= a;
            op_q  <= op_t'(op);
            k     <= '0;
            cnt_q <= '0;
            acc   <= (op_t'(op) == OP_AND) || (op_t'(op) == OP_NAND);
          end
        end
        RUN: begin
          acc   <= acc_fold;
          k     <= k + KW'(1);
          cnt_q <= cnt_q + CW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mixed_reduce_gate.sv
// Bench for mixed_reduce_gate (WIDTH=16, CHUNK=4): transaction-level model with a
// per-cycle compare, directed literal cases, and randomized traffic with resets.
module tb_mixed_reduce_gate;
  localparam int W = 16;
  localparam int C = 4;
  localparam int N = W / C;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] a = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic         f;
  logic [2:0]   cnt;

  int errors = 0;
  int checks = 0;
  bit done_flag = 1'b0;

  mixed_reduce_gate #(.WIDTH(W), .CHUNK(C)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op), .a(a),
    .out_valid(out_valid), .out_ready(out_ready), .f(f), .cnt(cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Result and chunk count straight from the reduction rules.
  function automatic void model_op(input logic [1:0] o, input logic [W-1:0] av,
                                   output bit ef, output int ec);
    logic [W-1:0] sh;
    ec = N;
    for (int i = 0; i < N; i++) begin
      sh = av >> (i * C);
      if ((o == 2'b00 || o == 2'b11) && sh[C-1:0] != {C{1'b1}}) begin ec = i + 1; break; end
      if (o == 2'b01 && sh[C-1:0] != '0) begin ec = i + 1; break; end
    end
    case (o)
      2'b00:   ef = &av;
      2'b01:   ef = |av;
      2'b10:   ef = ^av;
      default: ef = ~&av;
    endcase
  endfunction

  // Transaction-level model: idle / busy for cnt edges / holding result.
  int m_phase = 0;
  int m_remain = 0;
  bit m_f = 1'b0;
  int m_cnt = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase = 0;
    end else begin
      case (m_phase)
        0: if (in_valid) begin
             model_op(op, a, m_f, m_cnt);
             m_remain = m_cnt;
             m_phase = 1;
           end
        1: begin
             m_remain--;
             if (m_remain == 0) m_phase = 2;
           end
        default: if (out_ready) m_phase = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (!done_flag) begin
      logic [5:0] exp_v, act_v;
      exp_v = {m_phase == 0, m_phase == 2, (m_phase == 2) ? m_f : 1'b0,
               (m_phase == 2) ? 3'(m_cnt) : 3'd0};
      act_v = {in_ready, out_valid, f, cnt};
      check("cycle {in_ready,out_valid,f,cnt}", 32'(act_v), 32'(exp_v));
    end
  end

  task automatic run_op(input string nm, input logic [1:0] o, input logic [W-1:0] av,
                        input bit ef, input int ec, input int hold);
    int lat;
    bit f0;
    logic [2:0] c0;
    check({nm, " in_ready before accept"}, 32'(in_ready), 1);
    in_valid = 1'b1; op = o; a = av;
    @(posedge clk); #1;
    in_valid = 1'b0; a = W'($urandom);
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    check({nm, " latency"}, lat, ec);
    check({nm, " f"}, 32'(f), 32'(ef));
    check({nm, " cnt"}, 32'(cnt), ec);
    f0 = f; c0 = cnt;
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'($urandom); a = W'($urandom); op = 2'($urandom);
      @(posedge clk); #1;
      check({nm, " hold f"}, 32'(f), 32'(f0));
      check({nm, " hold cnt"}, 32'(cnt), 32'(c0));
      check({nm, " hold out_valid"}, 32'(out_valid), 1);
      check({nm, " hold in_ready"}, 32'(in_ready), 0);
    end
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b0;
    check({nm, " released out_valid"}, 32'(out_valid), 0);
    check({nm, " no bypass in_ready"}, 32'(in_ready), 1);
  endtask

  initial begin
    bit ef;
    int ec;
    // Pin the model against hand-computed cases.
    model_op(2'b00, 16'hFFFF, ef, ec); check("model AND FFFF", {ef, ec[30:0]}, {1'b1, 31'd4});
    model_op(2'b00, 16'hFFF0, ef, ec); check("model AND FFF0", {ef, ec[30:0]}, {1'b0, 31'd1});
    model_op(2'b11, 16'hFFF0, ef, ec); check("model NAND FFF0", {ef, ec[30:0]}, {1'b1, 31'd1});
    model_op(2'b01, 16'h0100, ef, ec); check("model OR 0100", {ef, ec[30:0]}, {1'b1, 31'd3});
    model_op(2'b10, 16'h0007, ef, ec); check("model XOR 0007", {ef, ec[30:0]}, {1'b1, 31'd4});

    #12;
    check("reset in_ready", 32'(in_ready), 1);
    check("reset out_valid", 32'(out_valid), 0);
    check("reset f/cnt", 32'({f, cnt}), 0);
    @(negedge clk); rst = 1'b0;

    run_op("AND FFFF", 2'b00, 16'hFFFF, 1'b1, 4, 0);
    run_op("AND FFF0", 2'b00, 16'hFFF0, 1'b0, 1, 0);
    run_op("NAND FFF0", 2'b11, 16'hFFF0, 1'b1, 1, 0);
    run_op("OR 0100", 2'b01, 16'h0100, 1'b1, 3, 0);
    run_op("OR 0000", 2'b01, 16'h0000, 1'b0, 4, 0);
    run_op("XOR 8001", 2'b10, 16'h8001, 1'b0, 4, 0);
    run_op("XOR 0007", 2'b10, 16'h0007, 1'b1, 4, 5);

    in_valid = 1'b1; op = 2'b00; a = 16'hFFFF;
    @(posedge clk); #1; in_valid = 1'b0;
    @(posedge clk); #2;
    rst = 1'b1; #1;
    check("mid-run reset in_ready", 32'(in_ready), 1);
    check("mid-run reset out_valid", 32'(out_valid), 0);
    check("mid-run reset f/cnt", 32'({f, cnt}), 0);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    run_op("AND FFFF after reset", 2'b00, 16'hFFFF, 1'b1, 4, 0);

    for (int i = 0; i < 600; i++) begin
      int r;
      @(posedge clk); #1;
      in_valid = 1'($urandom);
      op = 2'($urandom);
      r = $urandom_range(0, 3);
      case (r)
        0: a = W'($urandom);
        1: a = 16'hFFFF ^ (16'h1 << $urandom_range(0, 15));
        2: a = 16'h1 << $urandom_range(0, 15);
        default: a = ($urandom % 2) ? 16'hFFFF : 16'h0000;
      endcase
      out_ready = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 60) == 0) begin
        #1 rst = 1'b1;
        #1 rst = 1'b0;
      end
    end

    @(posedge clk); #1;
    done_flag = 1'b1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
